// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes and arbiter FSM encoding
package alu_pkg;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 5;
  localparam int SHAMT_W = 5;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant, pointer moves to the loser on accept
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr;
  always_ff @(posedge clk)
    ptr <= rst ? 1'b0 : accept ? grant[0] : ptr;
  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~ptr);
    grant[1] = valid[1] & (~valid[0] | ptr);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters; ALU_ARB_OVF_EN enables overflow reporting
module alu_arbiter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OP_W-1:0]    req0_opcode,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OP_W-1:0]    req1_opcode,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,
  output logic               rsp0_ovf,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,
  output logic               rsp1_ovf,
  output logic [OP_W-1:0]    alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_ovf
);
  state_t state, state_n;
  logic [1:0] grant;
  logic accept, owner, ovf_q;
  logic [DATA_W-1:0] result_q;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .valid({req1_valid, req0_valid}), .accept(accept), .grant(grant));
  assign accept = (state == IDLE) & |grant;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (accept ? EXEC : IDLE) :
              state == EXEC ? RESP :
              ((owner ? rsp1_ready : rsp0_ready) ? IDLE : RESP);
  always_comb begin
    req0_ready  = accept & grant[0];
    req1_ready  = accept & grant[1];
    rsp0_valid  = (state == RESP) & ~owner;
    rsp1_valid  = (state == RESP) & owner;
    rsp0_result = result_q;
    rsp1_result = result_q;
    rsp0_ovf    = ovf_q;
    rsp1_ovf    = ovf_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
      owner      <= 1'b0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
        alu_a      <= grant[1] ? req1_a : req0_a;
        alu_b      <= grant[1] ? req1_b : req0_b;
        alu_shamt  <= grant[1] ? req1_shamt : req0_shamt;
        owner      <= grant[1];
      end
      if (state == EXEC) result_q <= alu_result;
    end
`ifdef ALU_ARB_OVF_EN
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (state == EXEC) ovf_q <= alu_ovf & (alu_opcode == OP_ADD || alu_opcode == OP_SUB);
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
  assign ovf_q = 1'b0;
`endif
endmodule
